// File: rtl/e203_ifu_flush_ctrl_pkg.sv
// Shared sizing and FSM state type for the IFU flush controller.
package e203_ifu_flush_ctrl_pkg;

  localparam int unsigned DEF_PC_SIZE  = 32;
  localparam int unsigned DEF_OUTS_W   = 2;
  localparam int unsigned DEF_MAX_OUTS = 2;
  localparam int unsigned FLUSH_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } flush_state_e;

endpackage

// File: rtl/e203_ifu_outs_cnt.sv
// Saturating up/down counter of in-flight ifetch requests; exposes next value for lookahead.
module e203_ifu_outs_cnt #(
  parameter int unsigned OUTS_W   = 2,
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [OUTS_W-1:0] cnt_o,
  output logic [OUTS_W-1:0] cnt_nxt_o
);

  localparam logic [OUTS_W-1:0] MAX_V = OUTS_W'(MAX_OUTS);

  logic [OUTS_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; each direction clamps at its bound.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q < MAX_V) cnt_d = cnt_q + OUTS_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - OUTS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// IFU receiver of commit-stage flushes: acks, drains outstanding fetches, then redirects PC-gen once.
module e203_ifu_flush_ctrl
  import e203_ifu_flush_ctrl_pkg::*;
#(
  parameter int unsigned PC_SIZE  = DEF_PC_SIZE,
  parameter int unsigned OUTS_W   = DEF_OUTS_W,
  parameter int unsigned MAX_OUTS = DEF_MAX_OUTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   excp_flush_req,
  output logic                   excp_flush_ack,
  input  logic [PC_SIZE-1:0]     excp_flush_pc,
  input  logic                   brchmis_flush_req,
  output logic                   brchmis_flush_ack,
  input  logic [PC_SIZE-1:0]     brchmis_flush_add_op1,
  input  logic [PC_SIZE-1:0]     brchmis_flush_add_op2,
  input  logic                   ifetch_req_hsked,
  input  logic                   ifetch_rsp_hsked,
  output logic                   fetch_block,
  output logic                   drop_rsp,
  output logic                   redirect_valid,
  output logic [PC_SIZE-1:0]     redirect_pc,
  input  logic                   redirect_ready,
  output logic [OUTS_W-1:0]      outs_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  flush_state_e             state_q, state_d;
  logic [PC_SIZE-1:0]       target_q, target_d;
  logic [FLUSH_CNT_W-1:0]   flush_cnt_q;
  logic [OUTS_W-1:0]        outs_cur, outs_nxt;
  logic [PC_SIZE-1:0]       brch_target;
  logic                     flush_acc;

  e203_ifu_outs_cnt #(
    .OUTS_W   (OUTS_W),
    .MAX_OUTS (MAX_OUTS)
  ) u_outs_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (1'b0),
    .inc_i     (ifetch_req_hsked),
    .dec_i     (ifetch_rsp_hsked),
    .cnt_o     (outs_cur),
    .cnt_nxt_o (outs_nxt)
  );

  // Exception flushes are taken anywhere; branch flushes only when idle and unopposed.
  assign excp_flush_ack    = excp_flush_req;
  assign brchmis_flush_ack = brchmis_flush_req & ~excp_flush_req & (state_q == ST_IDLE);
  assign flush_acc         = excp_flush_ack | brchmis_flush_ack;
  assign brch_target       = brchmis_flush_add_op1 + brchmis_flush_add_op2;

  always_comb begin
    target_d = target_q;
    if (flush_acc) begin
      target_d    = excp_flush_ack ? excp_flush_pc : brch_target;
      target_d[0] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_acc) begin
      state_d = (outs_nxt == '0) ? ST_REDIR : ST_DRAIN;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_DRAIN: if (outs_nxt == '0) state_d = ST_REDIR;
        ST_REDIR: if (redirect_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      flush_cnt_q <= flush_cnt_q + FLUSH_CNT_W'(flush_acc);
    end
  end

  // Responses landing in the accept cycle still belong to the squashed stream.
  assign fetch_block    = (state_q != ST_IDLE) | flush_acc;
  assign drop_rsp       = (state_q == ST_DRAIN) | flush_acc;
  assign redirect_valid = (state_q == ST_REDIR);
  assign redirect_pc    = target_q;
  assign outs_cnt       = outs_cur;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_e203_ifu_flush_ctrl.sv
// Directed and randomized bench for e203_ifu_flush_ctrl against a flush-in-progress/outstanding-count model.
module tb_e203_ifu_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        excp_flush_req, brchmis_flush_req;
  logic        excp_flush_ack, brchmis_flush_ack;
  logic [31:0] excp_flush_pc, brchmis_flush_add_op1, brchmis_flush_add_op2;
  logic        ifetch_req_hsked, ifetch_rsp_hsked;
  logic        fetch_block, drop_rsp, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [1:0]  outs_cnt;
  logic [31:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a flush is "busy" from acceptance until its redirect is taken.
  logic        m_busy;
  int          m_outs;
  logic [31:0] m_target;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  e203_ifu_flush_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .excp_flush_req(excp_flush_req), .excp_flush_ack(excp_flush_ack), .excp_flush_pc(excp_flush_pc),
    .brchmis_flush_req(brchmis_flush_req), .brchmis_flush_ack(brchmis_flush_ack),
    .brchmis_flush_add_op1(brchmis_flush_add_op1), .brchmis_flush_add_op2(brchmis_flush_add_op2),
    .ifetch_req_hsked(ifetch_req_hsked), .ifetch_rsp_hsked(ifetch_rsp_hsked),
    .fetch_block(fetch_block), .drop_rsp(drop_rsp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .outs_cnt(outs_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clear_inputs();
    excp_flush_req = 0; brchmis_flush_req = 0;
    excp_flush_pc = 0; brchmis_flush_add_op1 = 0; brchmis_flush_add_op2 = 0;
    ifetch_req_hsked = 0; ifetch_rsp_hsked = 0; redirect_ready = 0;
  endtask

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    logic acc_e, acc_b;
    int   nxt;
    @(posedge clk);
    acc_e = excp_flush_req;
    acc_b = brchmis_flush_req & ~excp_flush_req & ~m_busy;
    nxt = m_outs + int'(ifetch_req_hsked) - int'(ifetch_rsp_hsked);
    if (nxt < 0) nxt = 0;
    if (nxt > 2) nxt = 2;
    if (rst_n) begin
      m_busy = 0; m_outs = 0; m_target = 0; m_cnt = 0;
    end else begin
      if (acc_e | acc_b) begin
        m_target    = acc_e ? excp_flush_pc : brchmis_flush_add_op1 + brchmis_flush_add_op2;
        m_target[0] = 1'b0;
        m_busy      = 1'b1;
        m_cnt       = m_cnt + 1;
      end else if (m_busy && m_outs == 0 && redirect_ready) begin
        m_busy = 1'b0;
      end
      m_outs = nxt;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1; tick(); tick();
    rst_n = 0; #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", redirect_valid); end
    n_cmp++; if (outs_cnt !== 2'd0) begin n_err++; $display("FAIL reset_outs: got %0d expected 0", outs_cnt); end
    n_cmp++; if (flush_cnt !== 32'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    n_cmp++; if (redirect_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", redirect_pc); end
    n_cmp++; if ({fetch_block, drop_rsp, excp_flush_ack, brchmis_flush_ack} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {fetch_block, drop_rsp, excp_flush_ack, brchmis_flush_ack}); end
  endtask

  task automatic test_brch_simple();
    brchmis_flush_req = 1; brchmis_flush_add_op1 = 32'h8000_0000; brchmis_flush_add_op2 = 32'h10; #1;
    n_cmp++; if (brchmis_flush_ack !== 1'b1) begin n_err++; $display("FAIL brch_ack: got %b expected 1", brchmis_flush_ack); end
    n_cmp++; if (fetch_block !== 1'b1) begin n_err++; $display("FAIL brch_fetch_block: got %b expected 1", fetch_block); end
    tick();
    brchmis_flush_req = 0; #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL brch_valid: got %b expected 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h8000_0010) begin n_err++; $display("FAIL brch_pc: got %h expected 80000010", redirect_pc); end
    redirect_ready = 1; tick();
    redirect_ready = 0; #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL brch_done: got %b expected 0", redirect_valid); end
  endtask

  task automatic test_drain();
    ifetch_req_hsked = 1; tick(); tick();
    ifetch_req_hsked = 0; #1;
    n_cmp++; if (outs_cnt !== 2'd2) begin n_err++; $display("FAIL drain_outs: got %0d expected 2", outs_cnt); end
    brchmis_flush_req = 1; brchmis_flush_add_op1 = 32'h100; brchmis_flush_add_op2 = 32'h0FF; tick();
    brchmis_flush_req = 0;
    for (int i = 0; i < 2; i++) begin
      ifetch_rsp_hsked = 1; #1;
      n_cmp++; if (drop_rsp !== 1'b1) begin n_err++; $display("FAIL drain_drop%0d: got %b expected 1", i, drop_rsp); end
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL drain_early%0d: got %b expected 0", i, redirect_valid); end
      tick();
    end
    ifetch_rsp_hsked = 0; #1;
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid: got %b expected 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h1FE) begin n_err++; $display("FAIL drain_pc: got %h expected 000001fe", redirect_pc); end
    n_cmp++; if (drop_rsp !== 1'b0) begin n_err++; $display("FAIL drain_drop_end: got %b expected 0", drop_rsp); end
    redirect_ready = 1; tick(); redirect_ready = 0;
  endtask

  task automatic test_simultaneous();
    excp_flush_req = 1; excp_flush_pc = 32'h200;
    brchmis_flush_req = 1; brchmis_flush_add_op1 = 32'h1000; brchmis_flush_add_op2 = 32'h20; #1;
    n_cmp++; if ({excp_flush_ack, brchmis_flush_ack} !== 2'b10) begin
      n_err++; $display("FAIL simul_acks: got %b expected 10", {excp_flush_ack, brchmis_flush_ack}); end
    tick();
    excp_flush_req = 0; #1;
    n_cmp++; if (brchmis_flush_ack !== 1'b0) begin n_err++; $display("FAIL simul_brch_pending: got %b expected 0", brchmis_flush_ack); end
    n_cmp++; if (redirect_pc !== 32'h200) begin n_err++; $display("FAIL simul_pc: got %h expected 00000200", redirect_pc); end
    redirect_ready = 1; tick();
    redirect_ready = 0; #1;
    n_cmp++; if (brchmis_flush_ack !== 1'b1) begin n_err++; $display("FAIL simul_brch_later: got %b expected 1", brchmis_flush_ack); end
    tick();
    brchmis_flush_req = 0; #1;
    n_cmp++; if (redirect_pc !== 32'h1020) begin n_err++; $display("FAIL simul_pc2: got %h expected 00001020", redirect_pc); end
    redirect_ready = 1; tick(); redirect_ready = 0;
  endtask

  task automatic test_hold();
    brchmis_flush_req = 1; brchmis_flush_add_op1 = 32'h4000; brchmis_flush_add_op2 = 32'h3; tick();
    brchmis_flush_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4002) begin
        n_err++; $display("FAIL hold_%0d: got valid=%b pc=%h expected valid=1 pc=00004002", i, redirect_valid, redirect_pc); end
      tick();
    end
    excp_flush_req = 1; excp_flush_pc = 32'h300; #1;
    n_cmp++; if (excp_flush_ack !== 1'b1) begin n_err++; $display("FAIL hold_excp_ack: got %b expected 1", excp_flush_ack); end
    tick();
    excp_flush_req = 0; #1;
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
      n_err++; $display("FAIL hold_retarget: got valid=%b pc=%h expected valid=1 pc=00000300", redirect_valid, redirect_pc); end
    redirect_ready = 1; tick(); redirect_ready = 0;
  endtask

  task automatic test_reset_drain();
    ifetch_req_hsked = 1; tick();
    ifetch_req_hsked = 0;
    brchmis_flush_req = 1; brchmis_flush_add_op1 = 32'h40; brchmis_flush_add_op2 = 32'h0; tick();
    brchmis_flush_req = 0; #1;
    n_cmp++; if (drop_rsp !== 1'b1) begin n_err++; $display("FAIL rstdrain_in_drain: got %b expected 1", drop_rsp); end
    rst_n = 1; tick();
    rst_n = 0; #1;
    n_cmp++; if (outs_cnt !== 2'd0 || flush_cnt !== 32'd0 || fetch_block !== 1'b0) begin
      n_err++; $display("FAIL rstdrain_cleared: got outs=%0d cnt=%0d fb=%b expected 0 0 0", outs_cnt, flush_cnt, fetch_block); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rstdrain_noredir%0d: got %b expected 0", i, redirect_valid); end
      tick();
    end
  endtask

  task automatic test_saturation();
    ifetch_rsp_hsked = 1; tick();
    ifetch_rsp_hsked = 0; #1;
    n_cmp++; if (outs_cnt !== 2'd0) begin n_err++; $display("FAIL sat_low: got %0d expected 0", outs_cnt); end
    ifetch_req_hsked = 1; tick(); tick(); tick();
    ifetch_req_hsked = 0; #1;
    n_cmp++; if (outs_cnt !== 2'd2) begin n_err++; $display("FAIL sat_high: got %0d expected 2", outs_cnt); end
    ifetch_rsp_hsked = 1; tick(); tick();
    ifetch_rsp_hsked = 0; #1;
    n_cmp++; if (outs_cnt !== 2'd0) begin n_err++; $display("FAIL sat_drain: got %0d expected 0", outs_cnt); end
  endtask

  task automatic test_random();
    logic br_hold;
    logic e_back, e_acc, e_fb, e_drop, e_valid;
    br_hold = 0;
    for (int c = 0; c < 600; c++) begin
      excp_flush_req = ($urandom_range(0, 11) == 0);
      excp_flush_pc  = $urandom();
      if (!br_hold && $urandom_range(0, 4) == 0) begin
        br_hold = 1;
        brchmis_flush_add_op1 = $urandom();
        brchmis_flush_add_op2 = $urandom();
      end
      brchmis_flush_req = br_hold;
      e_back  = brchmis_flush_req & ~excp_flush_req & ~m_busy;
      e_acc   = excp_flush_req | e_back;
      e_fb    = m_busy | e_acc;
      e_drop  = (m_busy && m_outs > 0) | e_acc;
      e_valid = m_busy && (m_outs == 0);
      ifetch_req_hsked = !e_fb && ($urandom_range(0, 1) == 1);
      ifetch_rsp_hsked = ($urandom_range(0, 2) == 0);
      redirect_ready   = ($urandom_range(0, 1) == 1);
      #1;
      n_cmp++; if ({excp_flush_ack, brchmis_flush_ack} !== {excp_flush_req, e_back}) begin
        n_err++; $display("FAIL rnd_acks c%0d: got %b expected %b", c, {excp_flush_ack, brchmis_flush_ack}, {excp_flush_req, e_back}); end
      n_cmp++; if ({fetch_block, drop_rsp, redirect_valid} !== {e_fb, e_drop, e_valid}) begin
        n_err++; $display("FAIL rnd_flags c%0d: got fb/drop/valid=%b expected %b", c, {fetch_block, drop_rsp, redirect_valid}, {e_fb, e_drop, e_valid}); end
      n_cmp++; if (redirect_pc !== m_target) begin
        n_err++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, redirect_pc, m_target); end
      n_cmp++; if (outs_cnt !== 2'(m_outs) || flush_cnt !== m_cnt) begin
        n_err++; $display("FAIL rnd_counts c%0d: got outs=%0d cnt=%0d expected outs=%0d cnt=%0d", c, outs_cnt, flush_cnt, m_outs, m_cnt); end
      if (e_back) br_hold = 0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    m_busy = 0; m_outs = 0; m_target = 0; m_cnt = 0;
    rst_n = 1;
    test_reset();
    test_brch_simple();
    test_drain();
    test_simultaneous();
    test_hold();
    test_reset_drain();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
